// File: rtl/simd_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu_sequencer
// Description : Sequences one SIMD lane arithmetic unit over a vector of
//               cmd_count elements. A command (fn, two source bases, a
//               destination base, count) is accepted in IDLE. Operand reads
//               are streamed from the lane scratchpad, the ALU is fed from
//               the read-return stage, and results are written back in read
//               order to dst+i.
// Ports       : clk, reset (async, active-low)
//               cmd_*      : command handshake and fields
//               stall      : suppress read issue this cycle
//               rd_*       : dual-port scratchpad read (data 1 cycle later)
//               alu_*      : drive/return of the combinational ALU
//               wr_*       : result write strobe/address/data
//               busy, done : status (done is a one-cycle completion pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module simd_alu_sequencer #(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int ADDR_W        = 10,
    parameter int CNT_W         = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [FUNCTION_BITS-1:0] cmd_fn,
    input  logic [ADDR_W-1:0]        cmd_src0_addr,
    input  logic [ADDR_W-1:0]        cmd_src1_addr,
    input  logic [ADDR_W-1:0]        cmd_dst_addr,
    input  logic [CNT_W-1:0]         cmd_count,
    input  logic                     stall,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr0,
    output logic [ADDR_W-1:0]        rd_addr1,
    input  logic [BIT_WIDTH-1:0]     rd_data0,
    input  logic [BIT_WIDTH-1:0]     rd_data1,
    output logic [FUNCTION_BITS-1:0] alu_fn,
    output logic [BIT_WIDTH-1:0]     alu_in0,
    output logic [BIT_WIDTH-1:0]     alu_in1,
    input  logic [BIT_WIDTH-1:0]     alu_out,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [BIT_WIDTH-1:0]     wr_data,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [FUNCTION_BITS-1:0] r_fn;
    logic [ADDR_W-1:0]        r_src0;
    logic [ADDR_W-1:0]        r_src1;
    logic [ADDR_W-1:0]        r_dst;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         r_issued;
    logic [CNT_W-1:0]         r_wr_idx;
    logic                     r_s1_valid;   // read data returning this cycle
    logic                     r_wr_en;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic [BIT_WIDTH-1:0]     r_wr_data;

    logic                     w_accept;
    logic                     w_rd_en;
    logic                     w_cmd_ready;
    logic                     w_done;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_accept     = 1'b0;
        w_rd_en      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (cmd_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    w_rd_en = 1'b1;
                    // r_count is non-zero here, so count-1 cannot underflow
                    if (r_issued == (r_count - CNT_W'(1))) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // With S1 empty, the only remaining item is the write
                // presented this cycle, so completion can follow next cycle.
                if (!r_s1_valid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, command latch and pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_fn       <= '0;
            r_src0     <= '0;
            r_src1     <= '0;
            r_dst      <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_wr_idx   <= '0;
            r_s1_valid <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_fn    <= cmd_fn;
                r_src0  <= cmd_src0_addr;
                r_src1  <= cmd_src1_addr;
                r_dst   <= cmd_dst_addr;
                r_count <= cmd_count;
            end

            if (w_accept) begin
                r_issued <= '0;
            end else if (w_rd_en) begin
                r_issued <= r_issued + CNT_W'(1);
            end

            // Pipeline advances every cycle; stall only gates new issue.
            r_s1_valid <= w_rd_en;
            r_wr_en    <= r_s1_valid;

            if (w_accept) begin
                r_wr_idx <= '0;
            end else if (r_s1_valid) begin
                r_wr_idx <= r_wr_idx + CNT_W'(1);
            end

            if (r_s1_valid) begin
                r_wr_data <= alu_out;
                r_wr_addr <= r_dst + ADDR_W'(r_wr_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready = w_cmd_ready;
    assign rd_en     = w_rd_en;
    // Addresses wrap modulo 2^ADDR_W; zero outside RUN.
    assign rd_addr0  = (r_state == ST_RUN) ? (r_src0 + ADDR_W'(r_issued)) : '0;
    assign rd_addr1  = (r_state == ST_RUN) ? (r_src1 + ADDR_W'(r_issued)) : '0;
    assign alu_fn    = (r_state == ST_IDLE) ? '0 : r_fn;
    assign alu_in0   = r_s1_valid ? rd_data0 : '0;
    assign alu_in1   = r_s1_valid ? rd_data1 : '0;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != ST_IDLE);
    assign done      = w_done;

endmodule
`default_nettype wire
